systolic_gemm_os: RTL and testbench
===================================

Name: systolic_gemm_os

Overview:
Parametrised successor to the dense INT8 array. It is an output-stationary N_ROWS×N_COLS GEMM engine computing C = A·B over a streamed reduction depth K.
- Both operand skews are built in.
- A tile FSM sequences compute, flush and result drain.
- Widths, signedness and saturation are configurable.
- A valid/ready result stream feeds the accel_top writeback path.

Parameters:
N_ROWS, 8, PE rows (rows of C)
N_COLS, 8, PE columns (columns of C)
DATA_W, 8, operand width
ACC_W, 32, accumulator width; must be ≥ 2*DATA_W
SAT, 1, 1 = saturating accumulate, 0 = two's-complement wrap

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_signed  in  1  1 = signed operands; sampled on first beat of a tile
in_valid  in  1  operand beat valid
in_ready  out  1  engine accepts beat
in_last  in  1  final beat (k = K-1) of tile
a_vec  in  N_ROWS*DATA_W  column k of A; row r at [r*DATA_W +: DATA_W]
b_vec  in  N_COLS*DATA_W  row k of B; column c at [c*DATA_W +: DATA_W]
out_valid  out  1  result row valid
out_ready  in  1  downstream accepts row
out_data  out  N_COLS*ACC_W  C[out_row][c] at [c*ACC_W +: ACC_W]
out_row  out  $clog2(N_ROWS) (min 1)  row index of out_data
out_last  out  1  high with final row (N_ROWS-1)
sat_flag  out  1  sticky: some accumulator saturated this tile; valid during DRAIN

Behaviour:
- Reset values: in_ready=1; out_valid=0; out_row=0; out_last=0; out_data=0; sat_flag=0; FSM=IDLE; all accumulators, skew registers and valid bits = 0. Reset takes effect immediately, including mid-tile or mid-drain, and discards the tile.
- FSM states: IDLE, COMPUTE, FLUSH, DRAIN.
- Handshake: a beat is accepted when in_valid & in_ready. in_ready=1 in IDLE and COMPUTE, 0 in FLUSH and DRAIN.
- IDLE→COMPUTE: on the first accepted beat. That beat latches cfg_signed and clears sat_flag. Each PE's first valid operand pair of the tile loads acc = product rather than accumulating.
- COMPUTE: each accepted beat pushes a_vec/b_vec, tagged valid, into the skew lines. Cycles with no accepted beat push zeros tagged invalid (bubble). Skew and forwarding registers advance every cycle. A PE accumulates only when its a and b valid tags are both set.
- Skew: row r of A is delayed r cycles; column c of B is delayed c cycles. PE(r,c) forwards a right and b down through one register each. Operand k therefore meets at PE(r,c) r+c cycles after the beat.
- COMPUTE→FSM=FLUSH: on an accepted beat with in_last=1. IDLE→FLUSH directly when the first beat has in_last=1 (K=1).
- FLUSH: counter runs N_ROWS+N_COLS-1 cycles, then DRAIN. out_valid rises exactly N_ROWS+N_COLS-1 cycles after the in_last handshake edge.
- DRAIN: presents rows 0..N_ROWS-1 in order.
  - out_data/out_row/out_last are held stable while out_valid & !out_ready.
  - Row advances on out_valid & out_ready.
  - Accepting the row with out_last=1 returns to IDLE. out_valid falls the next cycle; in_ready=1 the same cycle.
- Arithmetic:
  - Product is 2*DATA_W wide; signed (cfg_signed=1) or zero-extended, then sign/zero-extended to ACC_W+1.
  - SAT=1: the sum is clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1] in signed mode and [0, 2^ACC_W-1] in unsigned mode; any clamp sets sat_flag.
  - SAT=0: the sum wraps modulo 2^ACC_W and sat_flag stays 0.
- Accumulators hold their values after DRAIN until the next tile's first valid operand at each PE.
- in_valid=1 while in_ready=0 is ignored. The source must hold the beat.
- No per-row clock gating. The block is fully synchronous to clk.

Test Plan:
- N_ROWS=N_COLS=4, DATA_W=8, ACC_W=32. A=I (K=4), B[k][c]=4k+c, dense beats → rows 0..3 equal {0,1,2,3},{4,5,6,7},{8,9,10,11},{12,13,14,15}. out_valid first high exactly 7 cycles after the in_last handshake. out_last only on row 3.
- cfg_signed=1, all A=B=-128 (0x80), K=8 → every C=131072. Repeat with cfg_signed=0 and A=B=0xFF, K=8 → every C=520200. sat_flag=0 in both runs.
- ACC_W=16, SAT=1, signed, A=B=127, K=4 → every C=32767, sat_flag=1. With SAT=0 → every C=-1020, sat_flag=0.
- Same data as the first scenario, with in_valid deasserted on alternate cycles (bubbles) → identical results. in_ready=0 throughout FLUSH and DRAIN.
- out_ready low for 3 cycles at row 1, then toggling → out_data/out_row stable while stalled, no row skipped or duplicated. A second tile started immediately after DRAIN → correct new results with no carry-over from the first tile.
- rst_n asserted mid-DRAIN (row 2) → out_valid=0 and FSM=IDLE immediately. After release, in_ready=1 and a new K=1 tile with A=2, B=3 yields all C=6.

Source files
------------

// File: rtl/systolic_gemm_os.sv
// Output-stationary N_ROWS x N_COLS GEMM engine: C = A * B over a streamed
// reduction depth K. Row r of A and column c of B are skewed on entry so
// operand k meets PE(r,c) r+c cycles after its beat. A tile FSM sequences
// compute, flush and a row-by-row result drain.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready
// are both high. The source holds its payload stable while valid & !ready.
// ready may depend on state only, never on valid. in_ready is high in IDLE
// and COMPUTE. out_valid is high in DRAIN, and out_data/out_row/out_last
// stay frozen until the transfer completes.
module systolic_gemm_os #(
  parameter int N_ROWS = 8,
  parameter int N_COLS = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SAT    = 1,
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_signed,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [N_ROWS*DATA_W-1:0]   a_vec,
  input  logic [N_COLS*DATA_W-1:0]   b_vec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_COLS*ACC_W-1:0]    out_data,
  output logic [ROW_W-1:0]           out_row,
  output logic                       out_last,
  output logic                       sat_flag,
  output logic [1:0]                 dbg_state
);

  localparam int  FL_W   = $clog2(N_ROWS + N_COLS);
  localparam bit  SAT_EN = (SAT != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    FLUSH   = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [FL_W-1:0]   flush_cnt;
  logic [ROW_W-1:0]  row_q;
  logic              cfg_q;
  logic              accept;
  logic              tile_start;
  logic              any_hit;

  // Operand grid: a flows right along rows, b flows down along columns.
  logic [DATA_W-1:0] a_in [N_ROWS][N_COLS];
  logic              a_v  [N_ROWS][N_COLS];
  logic [DATA_W-1:0] b_in [N_ROWS][N_COLS];
  logic              b_v  [N_ROWS][N_COLS];
  logic [ACC_W-1:0]  acc_w [N_ROWS][N_COLS];
  logic              sat_hit [N_ROWS*N_COLS];

  assign accept    = in_valid & in_ready;
  assign in_ready  = (state == IDLE) || (state == COMPUTE);
  assign out_valid = (state == DRAIN);
  assign out_row   = row_q;
  assign out_last  = out_valid && (row_q == ROW_W'(N_ROWS - 1));
  assign dbg_state = state;

  // Tile sequencing: next state and single-cycle tile-start strobe.
  always_comb begin
    state_nxt  = state;
    tile_start = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          tile_start = 1'b1;
          state_nxt  = in_last ? FLUSH : COMPUTE;
        end
      end
      COMPUTE: if (accept && in_last) state_nxt = FLUSH;
      FLUSH:   if (flush_cnt == FL_W'(N_ROWS + N_COLS - 2)) state_nxt = DRAIN;
      DRAIN:   if (out_ready && (row_q == ROW_W'(N_ROWS - 1))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: state, flush timer, drain row, tile config and sticky saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flush_cnt <= '0;
      row_q     <= '0;
      cfg_q     <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
      if (state == DRAIN && out_ready)
        row_q <= (row_q == ROW_W'(N_ROWS - 1)) ? '0 : row_q + 1'b1;
      if (tile_start) cfg_q <= cfg_signed;
      if (tile_start)   sat_flag <= 1'b0;
      else if (any_hit) sat_flag <= 1'b1;
    end
  end

  // Row r of A enters through an input register plus r delay stages.
  for (genvar r = 0; r < N_ROWS; r++) begin : g_askew
    logic [DATA_W-1:0] sk_d [r+1];
    logic              sk_v [r+1];
    // Shift the A operand and its valid tag down the skew line.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= r; j++) begin
          sk_d[j] <= '0;
          sk_v[j] <= 1'b0;
        end
      end else begin
        sk_d[0] <= accept ? a_vec[r*DATA_W +: DATA_W] : '0;
        sk_v[0] <= accept;
        for (int j = 1; j <= r; j++) begin
          sk_d[j] <= sk_d[j-1];
          sk_v[j] <= sk_v[j-1];
        end
      end
    end
    assign a_in[r][0] = sk_d[r];
    assign a_v[r][0]  = sk_v[r];
  end

  // Column c of B enters through an input register plus c delay stages.
  for (genvar c = 0; c < N_COLS; c++) begin : g_bskew
    logic [DATA_W-1:0] sk_d [c+1];
    logic              sk_v [c+1];
    // Shift the B operand and its valid tag down the skew line.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= c; j++) begin
          sk_d[j] <= '0;
          sk_v[j] <= 1'b0;
        end
      end else begin
        sk_d[0] <= accept ? b_vec[c*DATA_W +: DATA_W] : '0;
        sk_v[0] <= accept;
        for (int j = 1; j <= c; j++) begin
          sk_d[j] <= sk_d[j-1];
          sk_v[j] <= sk_v[j-1];
        end
      end
    end
    assign b_in[0][c] = sk_d[c];
    assign b_v[0][c]  = sk_v[c];
  end

  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    for (genvar c = 0; c < N_COLS; c++) begin : g_pe
      logic                fire;
      logic [2*DATA_W-1:0] prod_s, prod_u;
      logic [ACC_W:0]      prod_x, base_x, sum;
      logic [ACC_W-1:0]    base, sat_val, acc_nxt, acc_q;
      logic                ovf, first_q;

      if (c < N_COLS - 1) begin : g_fwd_a
        logic [DATA_W-1:0] a_q;
        logic              a_qv;
        // Forward the A operand one PE to the right.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_q  <= '0;
            a_qv <= 1'b0;
          end else begin
            a_q  <= a_in[r][c];
            a_qv <= a_v[r][c];
          end
        end
        assign a_in[r][c+1] = a_q;
        assign a_v[r][c+1]  = a_qv;
      end

      if (r < N_ROWS - 1) begin : g_fwd_b
        logic [DATA_W-1:0] b_q;
        logic              b_qv;
        // Forward the B operand one PE down.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            b_q  <= '0;
            b_qv <= 1'b0;
          end else begin
            b_q  <= b_in[r][c];
            b_qv <= b_v[r][c];
          end
        end
        assign b_in[r+1][c] = b_q;
        assign b_v[r+1][c]  = b_qv;
      end

      // The first valid pair of a tile replaces the old result instead of adding to it.
      assign fire    = a_v[r][c] & b_v[r][c];
      assign prod_s  = $signed(a_in[r][c]) * $signed(b_in[r][c]);
      assign prod_u  = a_in[r][c] * b_in[r][c];
      assign prod_x  = cfg_q ? {{(ACC_W+1-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s}
                             : {{(ACC_W+1-2*DATA_W){1'b0}}, prod_u};
      assign base    = first_q ? '0 : acc_q;
      assign base_x  = cfg_q ? {base[ACC_W-1], base} : {1'b0, base};
      assign sum     = base_x + prod_x;
      assign ovf     = cfg_q ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
      assign sat_val = cfg_q ? (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                             : {ACC_W{1'b1}};
      assign acc_nxt = (SAT_EN && ovf) ? sat_val : sum[ACC_W-1:0];

      // Accumulate on matched valid operands; rearm the first-pair flag at tile start.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q   <= '0;
          first_q <= 1'b1;
        end else begin
          if (fire) acc_q <= acc_nxt;
          if (tile_start) first_q <= 1'b1;
          else if (fire)  first_q <= 1'b0;
        end
      end

      assign acc_w[r][c]          = acc_q;
      assign sat_hit[r*N_COLS+c]  = fire & ovf & SAT_EN;
    end
  end

  // Collapse per-PE clamp events into one tile-level hit.
  always_comb begin
    any_hit = 1'b0;
    for (int i = 0; i < N_ROWS*N_COLS; i++) any_hit = any_hit | sat_hit[i];
  end

  // Select the accumulator row currently being drained.
  always_comb begin
    out_data = '0;
    for (int c = 0; c < N_COLS; c++) out_data[c*ACC_W +: ACC_W] = acc_w[row_q][c];
  end

endmodule

// File: tb/tb_systolic_gemm_os.sv
// Bench for systolic_gemm_os: three 4x4 engines share one operand stream
// (ACC_W=32 saturating, ACC_W=16 saturating, ACC_W=16 wrapping). Expected
// rows come from a plain-arithmetic GEMM model and are queued per engine.
module tb_systolic_gemm_os;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int EW = 132;

  // ---------------- clock / reset ----------------
  logic clk, rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              cfg_signed, in_valid, in_last, out_ready;
  logic [N*DW-1:0]   a_vec, b_vec;
  logic              in_rdy [3];
  logic              ov [3];
  logic [1:0]        orow [3];
  logic              olast [3];
  logic              osat [3];
  logic [1:0]        dst [3];
  logic [N*32-1:0]   od32;
  logic [N*16-1:0]   od16s, od16w;
  logic [EW-1:0]     got [3];

  assign got[0] = {osat[0], olast[0], orow[0], od32};
  assign got[1] = {osat[1], olast[1], orow[1], 64'd0, od16s};
  assign got[2] = {osat[2], olast[2], orow[2], 64'd0, od16w};

  systolic_gemm_os #(.N_ROWS(N), .N_COLS(N), .DATA_W(DW), .ACC_W(32), .SAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_signed(cfg_signed), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .in_last(in_last), .a_vec(a_vec), .b_vec(b_vec), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od32), .out_row(orow[0]), .out_last(olast[0]), .sat_flag(osat[0]), .dbg_state(dst[0]));

  systolic_gemm_os #(.N_ROWS(N), .N_COLS(N), .DATA_W(DW), .ACC_W(16), .SAT(1)) u_s16 (
    .clk(clk), .rst_n(rst_n), .cfg_signed(cfg_signed), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .in_last(in_last), .a_vec(a_vec), .b_vec(b_vec), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od16s), .out_row(orow[1]), .out_last(olast[1]), .sat_flag(osat[1]), .dbg_state(dst[1]));

  systolic_gemm_os #(.N_ROWS(N), .N_COLS(N), .DATA_W(DW), .ACC_W(16), .SAT(0)) u_w16 (
    .clk(clk), .rst_n(rst_n), .cfg_signed(cfg_signed), .in_valid(in_valid), .in_ready(in_rdy[2]),
    .in_last(in_last), .a_vec(a_vec), .b_vec(b_vec), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od16w), .out_row(orow[2]), .out_last(olast[2]), .sat_flag(osat[2]), .dbg_state(dst[2]));

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q [3][$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [7:0]    ta  [N][16];
  logic [7:0]    tbm [16][N];
  int            rdy_mode = 0;
  int            stall_cnt = 0;

  task automatic check(input string name, input logic [EW-1:0] got_v, input logic [EW-1:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got_v, exp_v, $time);
    end
  endtask

  // Reference: one C element built by stepping k with the accumulate rule.
  function automatic logic [31:0] model_c(input int w, input bit sat_en, input bit sgn,
                                          input int kl, input int r, input int c, inout bit s);
    longint acc, p, lo, hi, m;
    m  = longint'(1) << w;
    lo = sgn ? -(m / 2) : 0;
    hi = sgn ? (m / 2 - 1) : (m - 1);
    acc = 0;
    for (int k = 0; k < kl; k++) begin
      if (sgn) p = longint'($signed(ta[r][k])) * longint'($signed(tbm[k][c]));
      else     p = longint'(ta[r][k]) * longint'(tbm[k][c]);
      acc = acc + p;
      if (sat_en) begin
        if (acc > hi)      begin acc = hi; s = 1'b1; end
        else if (acc < lo) begin acc = lo; s = 1'b1; end
      end else begin
        acc = acc & (m - 1);
        if (sgn && acc >= m / 2) acc = acc - m;
      end
    end
    return 32'(acc & (m - 1));
  endfunction

  task automatic push_expected(input int kl, input bit sgn);
    logic [31:0]   v [N][N];
    logic [EW-1:0] e;
    bit            s;
    int            w;
    bit            sat_en;
    for (int i = 0; i < 3; i++) begin
      w      = (i == 0) ? 32 : 16;
      sat_en = (i != 2);
      s      = 1'b0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) v[r][c] = model_c(w, sat_en, sgn, kl, r, c, s);
      for (int r = 0; r < N; r++) begin
        e = '0;
        for (int c = 0; c < N; c++) begin
          if (i == 0) e[c*32 +: 32] = v[r][c];
          else        e[c*16 +: 16] = v[r][c][15:0];
        end
        e[129:128] = 2'(r);
        e[130]     = (r == N - 1);
        e[131]     = s;
        exp_q[i].push_back(e);
      end
    end
  endtask

  // ---------------- tile loaders ----------------
  task automatic load_identity();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < N; j++) begin
        ta[j][k]  = (j == k) ? 8'd1 : 8'd0;
        tbm[k][j] = 8'(4 * k + j);
      end
  endtask

  task automatic load_const(input logic [7:0] av, input logic [7:0] bv, input int kl);
    for (int k = 0; k < kl; k++)
      for (int j = 0; j < N; j++) begin
        ta[j][k]  = av;
        tbm[k][j] = bv;
      end
  endtask

  task automatic load_random(input int kl);
    for (int k = 0; k < kl; k++)
      for (int j = 0; j < N; j++) begin
        ta[j][k]  = 8'($urandom_range(0, 255));
        tbm[k][j] = 8'($urandom_range(0, 255));
      end
  endtask

  // ---------------- driver ----------------
  task automatic issue_tile(input int kl, input bit sgn, input bit bubbles);
    bit ok;
    int guard;
    push_expected(kl, sgn);
    for (int k = 0; k < kl; k++) begin
      if (bubbles) begin
        in_valid = 1'b0;
        a_vec = 32'($urandom);
        b_vec = 32'($urandom);
        @(posedge clk); #1;
      end
      in_valid   = 1'b1;
      in_last    = (k == kl - 1);
      cfg_signed = (k == 0) ? sgn : 1'($urandom_range(0, 1));
      for (int j = 0; j < N; j++) begin
        a_vec[j*DW +: DW] = ta[j][k];
        b_vec[j*DW +: DW] = tbm[k][j];
      end
      guard = 0;
      ok = 1'b0;
      while (!ok && guard < 500) begin
        @(negedge clk);
        ok = in_rdy[0];
        @(posedge clk); #1;
        guard++;
      end
      if (!ok) check("beat_accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int  g;
    bit  done;
    done = 1'b0;
    g = 0;
    while (!done && g < 3000) begin
      @(posedge clk); #1;
      done = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (exp_q[2].size() == 0);
      g++;
    end
    check("drain_complete", done, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // out_ready pattern generator
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (ov[0] && orow[0] == 2'd1 && stall_cnt < 3) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else if (stall_cnt >= 3) out_ready = ~out_ready;
          else out_ready = 1'b1;
        end
        3: out_ready = !(ov[0] && orow[0] == 2'd2);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit            busy, post_last, prev_ov;
    bit            prev_stall [3];
    logic [EW-1:0] prev_got [3];
    int            last_hs;
    busy = 0; post_last = 0; prev_ov = 0; last_hs = 0;
    for (int i = 0; i < 3; i++) begin prev_stall[i] = 0; prev_got[i] = '0; end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0; post_last = 0; prev_ov = 0;
        for (int i = 0; i < 3; i++) prev_stall[i] = 0;
      end else begin
        if (post_last) begin
          check("after_last_out_valid", ov[0], 0);
          check("after_last_in_ready", in_rdy[0], 1);
          post_last = 0;
        end
        if (busy) check("in_ready_low_flush_drain", in_rdy[0], 0);
        if (ov[0] && !prev_ov) check("first_valid_latency", cyc - last_hs, 2 * N - 1);
        prev_ov = ov[0];
        for (int i = 0; i < 3; i++) begin
          if (prev_stall[i])
            check($sformatf("stall_hold_dut%0d", i), {ov[i], got[i]}, {1'b1, prev_got[i]});
          if (ov[i] && out_ready) begin
            if (exp_q[i].size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL unexpected_row_dut%0d got=%h exp=none", i, got[i]);
            end else begin
              check($sformatf("row_dut%0d", i), got[i], exp_q[i].pop_front());
            end
          end
          prev_stall[i] = ov[i] && !out_ready;
          prev_got[i]   = got[i];
        end
        if (ov[0] && out_ready && olast[0]) begin busy = 0; post_last = 1; end
        if (in_valid && in_rdy[0] && in_last) begin busy = 1; last_hs = cyc + 1; end
      end
    end
  end

  // watchdog
  initial begin
    #600000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    int kl;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; cfg_signed = 1'b0;
    a_vec = '0; b_vec = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_in_ready", in_rdy[0], 1);
    check("rst_out_valid", ov[0], 0);
    check("rst_out_row", orow[0], 0);
    check("rst_out_last", olast[0], 0);
    check("rst_out_data", od32, 0);
    check("rst_sat_flag", osat[0], 0);
    check("rst_state", dst[0], 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // identity A times counting B, dense beats
    load_identity(); issue_tile(4, 1'b0, 1'b0); wait_idle();
    // signed -128 squared, unsigned 255 squared
    load_const(8'h80, 8'h80, 8); issue_tile(8, 1'b1, 1'b0); wait_idle();
    load_const(8'hFF, 8'hFF, 8); issue_tile(8, 1'b0, 1'b0); wait_idle();
    // 127 squared: saturates/wraps in the 16-bit engines
    load_const(8'd127, 8'd127, 4); issue_tile(4, 1'b1, 1'b0); wait_idle();
    // identity again with alternate-cycle bubbles
    load_identity(); issue_tile(4, 1'b0, 1'b1); wait_idle();

    // stall at row 1 then toggling ready, second tile right behind
    rdy_mode = 2; stall_cnt = 0;
    load_random(5); issue_tile(5, 1'b1, 1'b0);
    load_random(3); issue_tile(3, 1'b0, 1'b0);
    wait_idle();

    // random back-to-back tiles with random ready
    rdy_mode = 1;
    for (int t = 0; t < 6; t++) begin
      kl = $urandom_range(1, 12);
      load_random(kl);
      issue_tile(kl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_idle();

    // reset while row 2 is being presented
    rdy_mode = 3;
    load_identity(); issue_tile(4, 1'b0, 1'b0);
    found = 1'b0;
    for (int g = 0; g < 200 && !found; g++) begin
      @(negedge clk);
      if (ov[0] && orow[0] == 2'd2) found = 1'b1;
    end
    check("reach_row2", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", ov[0], 0);
    check("midrst_state", dst[0], 0);
    check("midrst_in_ready", in_rdy[0], 1);
    check("midrst_out_data", od32, 0);
    for (int i = 0; i < 3; i++) exp_q[i].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    check("postrst_in_ready", in_rdy[0], 1);
    load_const(8'd2, 8'd3, 1); issue_tile(1, 1'($urandom_range(0, 1)), 1'b0); wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
